// File: rtl/autosym_pkg.sv
// autosym_pkg: shared types, default widths and the GF(2) masked-parity
// helper for the autosymmetric projection front-end (autosym_expander).
package autosym_pkg;

  localparam int N_IN_DEF  = 9;
  localparam int K_OUT_DEF = 5;

  // Widest vector the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 64;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Parity of x restricted to the positions selected by mask (one GF(2) dot product).
  function automatic logic masked_parity(input logic [PAR_MAX_W-1:0] x,
                                         input logic [PAR_MAX_W-1:0] mask);
    masked_parity = ^(x & mask);
  endfunction

endpackage

// File: rtl/gf2_parity_row.sv
// gf2_parity_row: one row of the GF(2) matrix-vector product, i.e. the
// parity of x masked by a single matrix row. Purely combinational.
module gf2_parity_row
  import autosym_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic [N_IN-1:0] x,
  input  logic [N_IN-1:0] mask,
  output logic            parity
);

  logic [PAR_MAX_W-1:0] x_ext_s;
  logic [PAR_MAX_W-1:0] mask_ext_s;

  assign x_ext_s    = PAR_MAX_W'(x);
  assign mask_ext_s = PAR_MAX_W'(mask);
  assign parity     = masked_parity(x_ext_s, mask_ext_s);

endmodule

// File: rtl/autosym_expander.sv
// autosym_expander: streaming projection z = A*x over GF(2) with a
// runtime-loaded K_OUT x N_IN matrix and a two-stage valid/ready pipeline.
// Optional feature macro: AUTOSYM_XOR_OFFSET_EN adds an offset vector b
// (written at cfg_row == K_OUT) so that z = A*x ^ b.
module autosym_expander
  import autosym_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEF,
  parameter  int K_OUT = K_OUT_DEF,
  localparam int ROW_W = $clog2(K_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [ROW_W-1:0] cfg_row,
  input  logic [N_IN-1:0]  cfg_data,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K_OUT-1:0] out_z
);

  state_e             state_r;
  logic [N_IN-1:0]    rows_r [K_OUT];
  logic [K_OUT-1:0]   row_ok_r;
  logic               cfg_err_r;
  logic               s1_valid_r;
  logic [N_IN-1:0]    s1_x_r;
  logic               s2_valid_r;
  logic [K_OUT-1:0]   s2_z_r;
`ifdef AUTOSYM_XOR_OFFSET_EN
  logic [K_OUT-1:0]   offset_r;
  logic               offset_sel_s;
`endif

  logic               pipe_empty_s;
  logic               s2_adv_s;
  logic               s1_take_s;
  logic               in_ready_s;
  logic               cfg_ready_s;
  logic               cfg_fire_s;
  logic               in_fire_s;
  logic               row_legal_s;
  logic [K_OUT-1:0]   row_ok_nxt_s;
  logic [K_OUT-1:0]   par_s;
  logic [K_OUT-1:0]   z_s;

  // Stage 2 can take new data when it is empty or its content leaves this cycle;
  // stage 1 moves whenever stage 2 can take, so both stall together in place.
  assign pipe_empty_s = ~s1_valid_r & ~s2_valid_r;
  assign s2_adv_s     = out_ready | ~s2_valid_r;
  assign s1_take_s    = ~s1_valid_r | s2_adv_s;
  assign in_ready_s   = (state_r == RUN) & s1_take_s;
  assign in_fire_s    = in_valid & in_ready_s;
  assign cfg_fire_s   = cfg_we & cfg_ready_s;
  assign row_legal_s  = (cfg_row < ROW_W'(K_OUT));
`ifdef AUTOSYM_XOR_OFFSET_EN
  assign offset_sel_s = (cfg_row == ROW_W'(K_OUT));
`endif

  // Configuration port availability by state; in DRAIN, rows may only change once the pipe is empty.
  always_comb begin
    cfg_ready_s = 1'b0;
    case (state_r)
      UNCFG:   cfg_ready_s = 1'b1;
      RUN:     cfg_ready_s = 1'b0;
      DRAIN:   cfg_ready_s = pipe_empty_s;
      default: cfg_ready_s = 1'b0;
    endcase
  end

  // Row-written bitmap as it will look after this cycle's write (illegal rows never count).
  always_comb begin
    row_ok_nxt_s = row_ok_r;
    if (cfg_fire_s && row_legal_s) begin
      row_ok_nxt_s[cfg_row] = 1'b1;
    end else begin
      row_ok_nxt_s = row_ok_r;
    end
  end

  // Control FSM: wait for a full matrix, stream, and drain before any row update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= UNCFG;
    end else begin
      case (state_r)
        UNCFG: begin
          if (&row_ok_r) state_r <= RUN;
          else           state_r <= UNCFG;
        end
        RUN: begin
          if (cfg_we) state_r <= DRAIN;
          else        state_r <= RUN;
        end
        DRAIN: begin
          if (!cfg_we)         state_r <= RUN;
          else if (cfg_fire_s) state_r <= (&row_ok_nxt_s) ? RUN : UNCFG;
          else                 state_r <= DRAIN;
        end
        default: state_r <= UNCFG;
      endcase
    end
  end

  // Matrix rows, written-row bitmap, optional offset and the sticky illegal-row flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K_OUT; i++) rows_r[i] <= {N_IN{1'b0}};
      row_ok_r  <= {K_OUT{1'b0}};
      cfg_err_r <= 1'b0;
`ifdef AUTOSYM_XOR_OFFSET_EN
      offset_r  <= {K_OUT{1'b0}};
`endif
    end else begin
      row_ok_r <= row_ok_nxt_s;
      if (cfg_fire_s) begin
        if (row_legal_s) begin
          rows_r[cfg_row] <= cfg_data;
`ifdef AUTOSYM_XOR_OFFSET_EN
        end else if (offset_sel_s) begin
          offset_r <= cfg_data[K_OUT-1:0];
`endif
        end else begin
          cfg_err_r <= 1'b1;
        end
      end
    end
  end

  // One parity tree per matrix row, fed by the stage-1 vector.
  for (genvar g = 0; g < K_OUT; g++) begin : g_row
    gf2_parity_row #(.N_IN(N_IN)) u_row (
      .x      (s1_x_r),
      .mask   (rows_r[g]),
      .parity (par_s[g])
    );
  end

`ifdef AUTOSYM_XOR_OFFSET_EN
  assign z_s = par_s ^ offset_r;
`else
  assign z_s = par_s;
`endif

  // Stage 1: capture accepted input vectors, hold while stage 2 is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_x_r     <= {N_IN{1'b0}};
    end else begin
      if (s1_take_s) begin
        s1_valid_r <= in_fire_s;
        if (in_fire_s) s1_x_r <= in_x;
      end
    end
  end

  // Stage 2: register the projected vector; z is only rewritten when new data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_z_r     <= {K_OUT{1'b0}};
    end else begin
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) s2_z_r <= z_s;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign cfg_ready = cfg_ready_s;
  assign cfg_err   = cfg_err_r;
  assign out_valid = s2_valid_r;
  assign out_z     = s2_z_r;

endmodule

// File: tb/tb_autosym_expander.sv
// tb_autosym_expander: directed vectors with hand-computed z values pushed
// into a scoreboard queue; a negedge monitor pops and compares each output.
module tb_autosym_expander;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_row;
  logic [8:0] cfg_data;
  logic       cfg_ready;
  logic       cfg_err;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_x;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_z;

  int         checks   = 0;
  int         failures = 0;
  int         n_out    = 0;
  int         last_wait;
  logic [4:0] exp_q[$];
  logic       held_v;
  logic [4:0] held_z;

  autosym_expander #(.N_IN(9), .K_OUT(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every output transfer and watch stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) check("stall_hold_z", 32'(out_z), 32'(held_z));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("out_z", 32'(out_z), 32'(exp_q.pop_front()));
        end
      end
      held_v = out_valid && !out_ready;
      held_z = out_z;
    end
  end

  // Called just after a rising edge; returns just after the edge that completed the write.
  task automatic write_row(input logic [2:0] row, input logic [8:0] data);
    int n;
    cfg_we = 1'b1; cfg_row = row; cfg_data = data;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 40) begin n++; @(negedge clk); end
    if (!cfg_ready) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Called just after a rising edge; pushes the expected z once the vector is accepted.
  task automatic send(input logic [8:0] x, input logic [4:0] exp);
    last_wait = 0;
    in_valid = 1'b1; in_x = x;
    @(negedge clk);
    while (!in_ready && last_wait < 40) begin last_wait++; @(negedge clk); end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin n++; @(negedge clk); end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_row = 3'd0; cfg_data = 9'h000;
    in_valid = 1'b0; in_x = 9'h000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_z", 32'(out_z), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Unconfigured: inputs are refused.
    in_valid = 1'b1; in_x = 9'h1A5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("uncfg_in_ready", 32'(in_ready), 32'd0);
      check("uncfg_out_valid", 32'(out_valid), 32'd0);
      check("uncfg_cfg_ready", 32'(cfg_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Identity matrix and latency / throughput.
    for (int i = 0; i < 5; i++) write_row(3'(i), 9'(1 << i));
    send(9'h1A5, 5'h05);
    @(negedge clk);
    check("latency_cycle1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_cycle2_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    send(9'h0FF, 5'h1F);
    check("throughput_wait0", 32'(last_wait), 32'd0);
    send(9'h155, 5'h15);
    check("throughput_wait1", 32'(last_wait), 32'd0);
    send(9'h0AA, 5'h0A);
    check("throughput_wait2", 32'(last_wait), 32'd0);
    wait_drain();

    // Backpressure: 4 vectors with out_ready low for 3 cycles.
    n0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        send(9'h003, 5'h03);
        send(9'h010, 5'h10);
        send(9'h11E, 5'h1E);
        send(9'h0A0, 5'h00);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_out_count", 32'(n_out - n0), 32'd4);

    // Row change with 2 vectors in flight: they use the old matrix.
    out_ready = 1'b0;
    send(9'h100, 5'h00);
    send(9'h0FF, 5'h1F);
    cfg_we = 1'b1; cfg_row = 3'd0; cfg_data = 9'h100;
    @(negedge clk);
    check("run_cfg_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    check("drain_full_cfg_ready", 32'(cfg_ready), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n0 = 0;
    @(negedge clk);
    while (!cfg_ready && n0 < 40) begin n0++; @(negedge clk); end
    check("drain_cfg_ready_rise", 32'(cfg_ready), 32'd1);
    check("drain_inflight_done", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    send(9'h100, 5'h01);
    wait_drain();

    // Illegal row: flagged, matrix untouched.
    check("cfg_err_before", 32'(cfg_err), 32'd0);
    write_row(3'd6, 9'h1FF);
    check("cfg_err_row6", 32'(cfg_err), 32'd1);
    send(9'h100, 5'h01);
    wait_drain();

`ifdef AUTOSYM_XOR_OFFSET_EN
    write_row(3'd0, 9'h001);
    write_row(3'd5, 9'h011);
    send(9'h000, 5'h11);
    send(9'h003, 5'h12);
    wait_drain();
    write_row(3'd5, 9'h000);
`else
    write_row(3'd5, 9'h011);
    check("cfg_err_row5", 32'(cfg_err), 32'd1);
    send(9'h000, 5'h00);
    wait_drain();
`endif

    // Single full-mask row: parity of all nine inputs on z[0].
    write_row(3'd0, 9'h1FF);
    for (int i = 1; i < 5; i++) write_row(3'(i), 9'h000);
    send(9'h0F3, 5'h00);
    send(9'h0F7, 5'h01);
    send(9'h1FF, 5'h01);
    wait_drain();

    // Mid-stream reset discards in-flight vectors.
    out_ready = 1'b0;
    send(9'h0AA, 5'h00);
    send(9'h055, 5'h01);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_z", 32'(out_z), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("midrst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_out_valid", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
